read_synch: RTL and testbench

- Read-side counterpart of the slow-device write synchronizer.
- A fast-clock requester asks for one word from a device clocked by the slow clock `slc`. `slc` is sampled as a data signal.
- The block drives an active-low read enable for exactly one full `slc` high phase and captures `din` on the `slc` falling edge.
- It returns the word with a one-cycle valid pulse. Sits between the fast-domain controller and slow peripherals (e.g. LCD/serial registers).

---
 rtl/synch_pkg.sv | 21 ++
 rtl/read_synch_if.sv | 25 ++
 rtl/slc_edge_det.sv | 31 +++
 rtl/read_synch.sv | 88 ++++++++
 tb/tb_read_synch.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/synch_pkg.sv
// Shared definitions for the slow-device read/write synchronizers: state
// encodings, default widths and the timeout counter sizing helper.
package synch_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ARM    = 3'd1;
  localparam state_t ST_STROBE = 3'd2;
  localparam state_t ST_DONE   = 3'd3;
  localparam state_t ST_HOLD   = 3'd4;

  localparam int DEF_DW      = 8;
  localparam int DEF_TIMEOUT = 255;

  // Counter must be able to hold TIMEOUT itself so it can saturate there.
  function automatic int cnt_width(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/read_synch_if.sv
// Requester/device-side signal bundle of the read synchronizer.
interface read_synch_if
  import synch_pkg::*;
#(
  parameter int DW = DEF_DW
) ();
  logic          rd;
  logic          slc;
  logic [DW-1:0] din;
  logic          rd_en_n;
  logic [DW-1:0] dout;
  logic          valid;
  logic          busy;
  logic          timeout;

  modport slave (
    input  rd, slc, din,
    output rd_en_n, dout, valid, busy, timeout
  );

  modport master (
    output rd, slc, din,
    input  rd_en_n, dout, valid, busy, timeout
  );
endinterface

// File: rtl/slc_edge_det.sv
// Slow-clock edge detector; READ_SYNCH_SLC_SYNC_EN inserts a 2-flop
// synchronizer ahead of the edge register for an asynchronous slc.
module slc_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic slc,
  output logic rise,
  output logic fall
);
  logic s;
  logic slc_q;

`ifdef READ_SYNCH_SLC_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= '0;
    else     sync <= {sync[0], slc};

  assign s = sync[1];
`else
  assign s = slc;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) slc_q <= 1'b0;
    else     slc_q <= s;

  assign rise = s & ~slc_q;
  assign fall = ~s & slc_q;
endmodule

// File: rtl/read_synch.sv
// Fast-domain read of one word from an slc-clocked device: enable spans one
// full slc high phase, data captured on the fall. Optional: READ_SYNCH_SLC_SYNC_EN.
module read_synch
  import synch_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic         clk,
  input logic         rst,
  read_synch_if.slave bus
);
  localparam int             CW       = cnt_width(TIMEOUT);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          expire;
  logic [DW-1:0] dout_r;
  logic          to_r;
  logic          rise;
  logic          fall;

  slc_edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .slc  (bus.slc),
    .rise (rise),
    .fall (fall)
  );

  // Shared ARM+STROBE budget; the bump that hits TIMEOUT also aborts.
  assign expire  = (cnt >= CNT_LAST);
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      dout_r <= '0;
      to_r   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:
          if (bus.rd) begin
            state <= ST_ARM;
            cnt   <= '0;
            to_r  <= 1'b0;
          end
        ST_ARM:
          // Only a true rise arms the strobe, so a phase already high is skipped.
          if (rise) state <= ST_STROBE;
          else begin
            cnt <= cnt_inc;
            if (expire) begin
              state <= ST_HOLD;
              to_r  <= 1'b1;
            end
          end
        ST_STROBE:
          if (fall) begin
            state  <= ST_DONE;
            dout_r <= bus.din;
          end else begin
            cnt <= cnt_inc;
            if (expire) begin
              state <= ST_HOLD;
              to_r  <= 1'b1;
            end
          end
        ST_DONE:
          state <= ST_HOLD;
        ST_HOLD:
          if (!bus.rd) state <= ST_IDLE;
        default:
          state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rd_en_n = (state != ST_STROBE);
  assign bus.busy    = (state != ST_IDLE);
  assign bus.valid   = (state == ST_DONE);
  assign bus.dout    = dout_r;
  assign bus.timeout = to_r;
endmodule

// File: tb/tb_read_synch.sv
// Bench for read_synch: slc runs 4 high / 4 low clk; a second instance with
// slc stuck low and TIMEOUT=10 covers the abort path.
module tb_read_synch;
`ifdef READ_SYNCH_SLC_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  read_synch_if #(.DW(8)) bus ();
  read_synch_if #(.DW(8)) bus_to ();

  read_synch #(.DW(8), .TIMEOUT(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  read_synch #(.DW(8), .TIMEOUT(10)) u_dut_to (
    .clk (clk),
    .rst (rst),
    .bus (bus_to)
  );

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int ph = 0;
  bit slc_run = 0;
  int last_rise = -100;
  int last_fall = -100;
  logic [7:0] sb[$];

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    if (slc_run) begin
      ph = (ph + 1) % 8;
      if (ph == 4) begin
        bus.slc = 1'b1;
        last_rise = cyc_n;
      end else if (ph == 0) begin
        bus.slc = 1'b0;
        last_fall = cyc_n;
      end
    end
  endtask

  task automatic wait_ph(input int p);
    for (int i = 0; i < 16 && ph != p; i++) cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    checks++;
    if (bus.rd_en_n !== 1'b1 || bus.busy !== 1'b0 || bus.valid !== 1'b0 ||
        bus.timeout !== 1'b0 || bus.dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_main: rd_en_n=%b busy=%b valid=%b timeout=%b dout=%h, want 1 0 0 0 00",
               bus.rd_en_n, bus.busy, bus.valid, bus.timeout, bus.dout);
    end
    checks++;
    if (bus_to.rd_en_n !== 1'b1 || bus_to.busy !== 1'b0 || bus_to.timeout !== 1'b0 ||
        bus_to.dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_to: rd_en_n=%b busy=%b timeout=%b dout=%h, want 1 0 0 00",
               bus_to.rd_en_n, bus_to.busy, bus_to.timeout, bus_to.dout);
    end
    rst = 1'b0;
    slc_run = 1;
    repeat (2) cyc();
  endtask

  task automatic test_basic();
    int en_cnt = 0, rise_d = -1, fall_d = -1;
    bit got = 0;
    logic [7:0] exp;
    wait_ph(0);
    bus.din = 8'hA5;
    bus.rd = 1'b1;
    sb.push_back(8'hA5);
    cyc();
    bus.rd = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (!bus.rd_en_n) begin
        if (en_cnt == 0) rise_d = cyc_n - last_rise;
        en_cnt++;
      end
      if (bus.valid) begin
        got = 1;
        fall_d = cyc_n - last_fall;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL basic_sb: valid with empty scoreboard, dout=%h", bus.dout);
        end else begin
          exp = sb.pop_front();
          if (bus.dout !== exp) begin
            errors++;
            $display("FAIL basic_dout: got %h want %h", bus.dout, exp);
          end
        end
      end else cyc();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL basic_valid: no valid within budget");
    end
    checks++;
    if (en_cnt != 4) begin
      errors++;
      $display("FAIL basic_en_span: got %0d want 4", en_cnt);
    end
    checks++;
    if (rise_d != 1 + SD) begin
      errors++;
      $display("FAIL basic_en_delay: got %0d want %0d", rise_d, 1 + SD);
    end
    checks++;
    if (fall_d != 1 + SD) begin
      errors++;
      $display("FAIL basic_valid_delay: got %0d want %0d", fall_d, 1 + SD);
    end
    cyc();
    checks++;
    if (bus.valid !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_hold: valid=%b busy=%b want 0 1", bus.valid, bus.busy);
    end
    cyc();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_high();
    int en_cnt = 0, rise_d = -1, t_req;
    bit got = 0, late = 0;
    logic [7:0] exp;
    wait_ph(5 + SD);
    bus.din = 8'h3C;
    bus.rd = 1'b1;
    sb.push_back(8'h3C);
    t_req = cyc_n;
    cyc();
    bus.rd = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (!bus.rd_en_n) begin
        if (en_cnt == 0) begin
          rise_d = cyc_n - last_rise;
          late = (last_rise > t_req);
        end
        en_cnt++;
      end
      if (bus.valid) begin
        got = 1;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL high_sb: valid with empty scoreboard, dout=%h", bus.dout);
        end else begin
          exp = sb.pop_front();
          if (bus.dout !== exp) begin
            errors++;
            $display("FAIL high_dout: got %h want %h", bus.dout, exp);
          end
        end
      end else cyc();
    end
    checks++;
    if (!got || !late || rise_d != 1 + SD) begin
      errors++;
      $display("FAIL high_wait_rise: got=%0d next_phase=%0d delay=%0d want 1 1 %0d",
               got, late, rise_d, 1 + SD);
    end
    checks++;
    if (en_cnt != 4) begin
      errors++;
      $display("FAIL high_en_span: got %0d want 4", en_cnt);
    end
    repeat (3) cyc();
  endtask

  task automatic test_held();
    int en_edges = 0, valids = 0, busy_low = 0;
    logic prev_en = 1'b1;
    logic [7:0] exp;
    wait_ph(0);
    bus.din = 8'h5A;
    bus.rd = 1'b1;
    sb.push_back(8'h5A);
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (!bus.rd_en_n && prev_en) en_edges++;
      prev_en = bus.rd_en_n;
      if (!bus.busy) busy_low++;
      if (bus.valid) begin
        valids++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL held_sb: extra valid, dout=%h", bus.dout);
        end else begin
          exp = sb.pop_front();
          if (bus.dout !== exp) begin
            errors++;
            $display("FAIL held_dout: got %h want %h", bus.dout, exp);
          end
        end
      end
    end
    checks++;
    if (valids != 1 || en_edges != 1) begin
      errors++;
      $display("FAIL held_once: valids=%0d enables=%0d want 1 1", valids, en_edges);
    end
    checks++;
    if (busy_low != 0) begin
      errors++;
      $display("FAIL held_busy: busy low %0d cycles while rd held, want 0", busy_low);
    end
    bus.rd = 1'b0;
    cyc();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL held_release: busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_timeout();
    int n_arm = 0, n_valid = 0;
    bit hit = 0;
    bus_to.din = 8'hFF;
    bus_to.rd = 1'b1;
    cyc();
    bus_to.rd = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (bus_to.valid) n_valid++;
      if (bus_to.timeout) hit = 1;
      else begin
        if (bus_to.busy) n_arm++;
        cyc();
      end
    end
    checks++;
    if (!hit || n_arm != 10) begin
      errors++;
      $display("FAIL timeout_cycles: hit=%0d arm_cycles=%0d want 1 10", hit, n_arm);
    end
    repeat (4) begin
      cyc();
      if (bus_to.valid) n_valid++;
    end
    checks++;
    if (n_valid != 0 || bus_to.dout !== 8'h00) begin
      errors++;
      $display("FAIL timeout_no_capture: valids=%0d dout=%h want 0 00", n_valid, bus_to.dout);
    end
    checks++;
    if (bus_to.timeout !== 1'b1 || bus_to.busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_held: timeout=%b busy=%b want 1 0", bus_to.timeout, bus_to.busy);
    end
    bus_to.rd = 1'b1;
    cyc();
    bus_to.rd = 1'b0;
    checks++;
    if (bus_to.timeout !== 1'b0 || bus_to.busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_clear: timeout=%b busy=%b want 0 1", bus_to.timeout, bus_to.busy);
    end
    repeat (14) cyc();
  endtask

  task automatic test_reset_mid();
    int en_cnt = 0, n_valid = 0;
    wait_ph(0);
    bus.din = 8'hC3;
    bus.rd = 1'b1;
    sb.push_back(8'hC3);
    cyc();
    bus.rd = 1'b0;
    for (int i = 0; i < 24 && en_cnt < 2; i++) begin
      cyc();
      if (!bus.rd_en_n) en_cnt++;
    end
    checks++;
    if (en_cnt != 2) begin
      errors++;
      $display("FAIL rstmid_reach: enable cycles seen %0d want 2", en_cnt);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.rd_en_n !== 1'b1 || bus.busy !== 1'b0 || bus.dout !== 8'h00 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: rd_en_n=%b busy=%b dout=%h valid=%b want 1 0 00 0",
               bus.rd_en_n, bus.busy, bus.dout, bus.valid);
    end
    sb.delete();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (bus.valid) n_valid++;
    end
    checks++;
    if (n_valid != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after: valids=%0d busy=%b want 0 0", n_valid, bus.busy);
    end
  endtask

  initial begin
    bus.rd = 1'b0;
    bus.slc = 1'b0;
    bus.din = 8'h00;
    bus_to.rd = 1'b0;
    bus_to.slc = 1'b0;
    bus_to.din = 8'h00;
    test_reset();
    test_basic();
    test_high();
    test_held();
    test_timeout();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d reads never returned, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
